fetch_stall_ctrl: RTL and testbench

FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

---
 rtl/fetch_stall_ctrl_pkg.sv | 28 ++
 rtl/fetch_stall_ctrl_sat_counter.sv | 38 +++
 rtl/fetch_stall_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stall_ctrl_pkg
// Shared definitions for the instruction-fetch stall/redirect controller:
//   - fetch_state_e    : controller state (RUN / DROP / HOLD)
//   - NOP_INSTR        : instruction word held in IF/ID after reset
//   - DEFAULT_RESET_PC : default fetch address after reset
//   - CNT_W            : width of the stall/flush event counters
//   - pc_incr()        : sequential next-PC helper (wraps modulo 2^32)
// ---------------------------------------------------------------------------
package fetch_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,   // normal fetching
      ST_DROP = 2'd1,   // redirect seen while a request was in flight
      ST_HOLD = 2'd2    // instruction parked in the skid buffer during a stall
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'h0000_0004;
   localparam int unsigned CNT_W            = 16;

   // Sequential next fetch address; natural 32-bit wrap.
   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_stall_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that increments once per cycle while inc=1 and sticks at
// its all-ones value instead of wrapping.
// Ports:
//   clk   in  1      rising-edge clock
//   rst_n in  1      synchronous active-low reset (clears the count)
//   inc   in  1      count this cycle
//   count out WIDTH  current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_r;

   // Count register: clear on reset, step on inc until saturated.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= {WIDTH{1'b0}};
      end else if (inc && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_stall_ctrl
// Instruction-fetch front end that reacts to pipeline hazards:
//   is_stall[1] redirects fetch to pc_branch (priority), is_stall[0] freezes
//   IF/ID for a load-use stall. A request that is still waiting for
//   imem_ready is never withdrawn or altered; a redirect arriving during such
//   a wait is remembered (DROP) and applied once the stale word returns, and
//   a word returning during a stall is parked in a skid buffer (HOLD).
// Ports:
//   clk          in  1   rising-edge clock
//   rst_n        in  1   synchronous active-low reset
//   is_stall     in  2   [1] redirect, [0] load-use stall
//   pc_branch    in  32  redirect target
//   imem_req     out 1   fetch request
//   imem_addr    out 32  fetch address (the pc register)
//   imem_ready   in  1   request accepted this cycle
//   imem_rdata   in  32  instruction word, valid when accepted
//   if_id_pc     out 32  IF/ID PC
//   if_id_instr  out 32  IF/ID instruction
//   if_id_valid  out 1   IF/ID holds a real instruction
//   id_ex_flush  out 1   bubble into ID/EX this cycle (combinational)
//   stall_cnt    out 16  saturating load-stall cycle count
//   flush_cnt    out 16  saturating redirect cycle count
// ---------------------------------------------------------------------------
module fetch_stall_ctrl
   import fetch_stall_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       is_stall,
   input  logic [31:0]      pc_branch,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_instr,
   output logic             if_id_valid,
   output logic             id_ex_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   fetch_state_e state_r, state_n;
   logic [31:0]  pc_r, pc_n;
   logic [31:0]  if_id_pc_r, if_id_pc_n;
   logic [31:0]  if_id_instr_r, if_id_instr_n;
   logic         if_id_valid_r, if_id_valid_n;
   logic [31:0]  skid_pc_r, skid_pc_n;
   logic [31:0]  skid_instr_r, skid_instr_n;
   logic [31:0]  target_r, target_n;
   logic         pending_r;
   logic         imem_req_s;
   logic         accepted_s;
   logic         stall_only_s;

   assign stall_only_s = (is_stall == 2'b01);

   // Fetch request per state; a pending request is always kept alive.
   always_comb begin
      imem_req_s = 1'b0;
      case (state_r)
         ST_RUN:  imem_req_s = !(stall_only_s && !pending_r);
         ST_DROP: imem_req_s = 1'b1;
         ST_HOLD: imem_req_s = 1'b0;
         default: imem_req_s = 1'b0;
      endcase
   end

   assign imem_req    = imem_req_s & rst_n;
   assign accepted_s  = imem_req & imem_ready;
   assign imem_addr   = pc_r;
   assign id_ex_flush = |is_stall;

   // Next-state and datapath update for IF/ID, pc, skid and redirect target.
   always_comb begin
      state_n       = state_r;
      pc_n          = pc_r;
      if_id_pc_n    = if_id_pc_r;
      if_id_instr_n = if_id_instr_r;
      if_id_valid_n = if_id_valid_r;
      skid_pc_n     = skid_pc_r;
      skid_instr_n  = skid_instr_r;
      target_n      = target_r;
      case (state_r)
         ST_RUN: begin
            if (is_stall[1]) begin
               if_id_valid_n = 1'b0;
               if (accepted_s || !imem_req_s) begin
                  pc_n = pc_branch;
               end else begin
                  // Request still in flight: wait for it, then redirect.
                  target_n = pc_branch;
                  state_n  = ST_DROP;
               end
            end else if (is_stall[0]) begin
               if (accepted_s) begin
                  // Only a pending request can be accepted here; park it.
                  skid_pc_n    = pc_r;
                  skid_instr_n = imem_rdata;
                  pc_n         = pc_incr(pc_r);
                  state_n      = ST_HOLD;
               end else begin
                  state_n = ST_RUN;
               end
            end else begin
               if (accepted_s) begin
                  if_id_pc_n    = pc_r;
                  if_id_instr_n = imem_rdata;
                  if_id_valid_n = 1'b1;
                  pc_n          = pc_incr(pc_r);
               end else begin
                  if_id_valid_n = 1'b0;
               end
            end
         end
         ST_DROP: begin
            if_id_valid_n = 1'b0;
            if (is_stall[1]) begin
               target_n = pc_branch;
            end else begin
               target_n = target_r;
            end
            if (accepted_s) begin
               // Stale word is dropped; the newest redirect target wins.
               pc_n    = is_stall[1] ? pc_branch : target_r;
               state_n = ST_RUN;
            end else begin
               state_n = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (is_stall[1]) begin
               if_id_valid_n = 1'b0;
               pc_n          = pc_branch;
               state_n       = ST_RUN;
            end else if (is_stall[0]) begin
               state_n = ST_HOLD;
            end else begin
               if_id_pc_n    = skid_pc_r;
               if_id_instr_n = skid_instr_r;
               if_id_valid_n = 1'b1;
               state_n       = ST_RUN;
            end
         end
         default: begin
            if_id_valid_n = 1'b0;
            state_n       = ST_RUN;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= ST_RUN;
         pc_r          <= RESET_PC;
         if_id_pc_r    <= 32'h0000_0000;
         if_id_instr_r <= NOP_INSTR;
         if_id_valid_r <= 1'b0;
         skid_pc_r     <= 32'h0000_0000;
         skid_instr_r  <= 32'h0000_0000;
         target_r      <= 32'h0000_0000;
         pending_r     <= 1'b0;
      end else begin
         state_r       <= state_n;
         pc_r          <= pc_n;
         if_id_pc_r    <= if_id_pc_n;
         if_id_instr_r <= if_id_instr_n;
         if_id_valid_r <= if_id_valid_n;
         skid_pc_r     <= skid_pc_n;
         skid_instr_r  <= skid_instr_n;
         target_r      <= target_n;
         pending_r     <= imem_req & ~imem_ready;
      end
   end

   assign if_id_pc    = if_id_pc_r;
   assign if_id_instr = if_id_instr_r;
   assign if_id_valid = if_id_valid_r;

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_only_s),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (is_stall[1]),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_stall_ctrl
// Scoreboard bench: the stimulus process drives one cycle of inputs, asks a
// queue-based reference model for the outputs that cycle should show and
// pushes them; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_stall_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  is_stall;
   logic [31:0] pc_branch;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        id_ex_flush;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   fetch_stall_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .is_stall    (is_stall),
      .pc_branch   (pc_branch),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
      .id_ex_flush (id_ex_flush),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk_state;
      logic        req;
      logic [31:0] addr;
      logic        flush;
      logic [31:0] ipc;
      logic [31:0] iinstr;
      logic        ivalid;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: undelivered fetched words and outstanding
   // redirect targets are held as queues.
   bit              m_known = 1'b0;
   logic [31:0]     m_pc;
   logic [31:0]     m_if_pc;
   logic [31:0]     m_if_instr;
   logic            m_if_valid;
   int unsigned     m_sc;
   int unsigned     m_fc;
   bit              m_pending;
   logic [31:0]     redirect_q[$];
   logic [63:0]     held_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: compare the DUT against the oldest expectation each falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
         chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e.flush});
         if (e.chk_state) begin
            chk("imem_addr", imem_addr, e.addr);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.ivalid});
            chk("if_id_pc", if_id_pc, e.ipc);
            chk("if_id_instr", if_id_instr, e.iinstr);
            chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.sc});
            chk("flush_cnt", {16'd0, flush_cnt}, {16'd0, e.fc});
         end
      end
   end

   // Drive one cycle, record the expected outputs, advance the model.
   task automatic step(input logic rs, input logic [1:0] st, input logic [31:0] br,
                       input logic rdy, input logic [31:0] rd);
      exp_t e;
      bit   req;
      bit   acc;
      rst_n      = rs;
      is_stall   = st;
      pc_branch  = br;
      imem_ready = rdy;
      imem_rdata = rd;

      if (!rs) req = 1'b0;
      else if (held_q.size() > 0) req = 1'b0;
      else if (redirect_q.size() > 0) req = 1'b1;
      else req = !(st == 2'b01 && !m_pending);
      acc = req && rdy;

      e.chk_state = m_known;
      e.req       = req;
      e.addr      = m_pc;
      e.flush     = (st != 2'b00);
      e.ipc       = m_if_pc;
      e.iinstr    = m_if_instr;
      e.ivalid    = m_if_valid;
      e.sc        = m_sc[15:0];
      e.fc        = m_fc[15:0];
      exp_q.push_back(e);

      if (!rs) begin
         m_known    = 1'b1;
         m_pc       = RST_PC;
         m_if_pc    = 32'h0000_0000;
         m_if_instr = NOP;
         m_if_valid = 1'b0;
         m_sc       = 0;
         m_fc       = 0;
         m_pending  = 1'b0;
         redirect_q.delete();
         held_q.delete();
      end else begin
         if (held_q.size() > 0) begin
            if (st[1]) begin
               held_q.delete();
               m_if_valid = 1'b0;
               m_pc = br;
            end else if (st == 2'b00) begin
               {m_if_pc, m_if_instr} = held_q.pop_front();
               m_if_valid = 1'b1;
            end
         end else if (redirect_q.size() > 0) begin
            m_if_valid = 1'b0;
            if (st[1]) redirect_q = '{br};
            if (acc) m_pc = redirect_q.pop_front();
         end else if (st[1]) begin
            m_if_valid = 1'b0;
            if (acc) m_pc = br;
            else redirect_q.push_back(br);
         end else if (st == 2'b01) begin
            if (acc) begin
               held_q.push_back({m_pc, rd});
               m_pc = m_pc + 32'd4;
            end
         end else if (acc) begin
            m_if_pc    = m_pc;
            m_if_instr = rd;
            m_if_valid = 1'b1;
            m_pc       = m_pc + 32'd4;
         end else begin
            m_if_valid = 1'b0;
         end
         if (st == 2'b01 && m_sc < 65535) m_sc++;
         if (st[1] && m_fc < 65535) m_fc++;
         m_pending = req && !rdy;
      end

      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 2'b00, 32'd0, 1'b1, 32'd0);
      step(1'b0, 2'b00, 32'd0, 1'b1, 32'd0);
   endtask

   task automatic fetch_n(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 2'b00, 32'd0, 1'b1, 32'hA000_0000 + i);
   endtask

   initial begin
      rst_n      = 1'b0;
      is_stall   = 2'b00;
      pc_branch  = 32'd0;
      imem_ready = 1'b0;
      imem_rdata = 32'd0;
      @(posedge clk);
      #1;

      // Reset release with constant ready: 0, 4, 8 ...
      do_reset();
      fetch_n(4);
      // Load-use stall at pc 0x10 with nothing pending, then resume.
      step(1'b1, 2'b01, 32'd0, 1'b1, 32'hDEAD_0001);
      fetch_n(2);
      // Redirect with ready high.
      step(1'b1, 2'b10, 32'h0000_0100, 1'b1, 32'hDEAD_0002);
      fetch_n(2);

      // Redirect while a request at 0x20 is pending.
      do_reset();
      fetch_n(8);
      step(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
      step(1'b1, 2'b10, 32'h0000_0100, 1'b0, 32'd0);
      step(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
      step(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
      step(1'b1, 2'b00, 32'd0, 1'b1, 32'hBAD0_0020);
      fetch_n(2);

      // Stall while a request at 0x30 is accepted: HOLD then deliver once.
      do_reset();
      fetch_n(12);
      step(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
      step(1'b1, 2'b01, 32'd0, 1'b1, 32'h1111_0030);
      step(1'b1, 2'b01, 32'd0, 1'b1, 32'h2222_2222);
      fetch_n(3);

      // Reset during DROP.
      step(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
      step(1'b1, 2'b10, 32'h0000_0200, 1'b0, 32'd0);
      step(1'b1, 2'b01, 32'd0, 1'b0, 32'd0);
      step(1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
      fetch_n(2);

      // Randomized traffic, including unaligned redirect targets.
      for (int i = 0; i < 3000; i++) begin
         int unsigned r;
         logic [1:0]  st;
         r = $urandom_range(0, 9);
         if (r < 5) st = 2'b00;
         else if (r < 7) st = 2'b01;
         else if (r < 9) st = 2'b10;
         else st = 2'b11;
         step(($urandom_range(0, 99) != 0), st, $urandom, ($urandom_range(0, 2) != 0), $urandom);
      end

      // Stall counter saturation.
      do_reset();
      for (int i = 0; i < 65540; i++) step(1'b1, 2'b01, 32'd0, i[0], 32'd0);
      step(1'b1, 2'b10, 32'h0000_0040, 1'b1, 32'd0);
      fetch_n(3);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
